// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM for the semiMIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mc_main_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       branch_ne,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [2:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t     st;
  logic [5:0] op_q;

  function automatic logic is_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_br(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_mem(op) || is_br(op) || is_imm(op) ||
           (op == OP_RTYPE) || (op == OP_J);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      op_q <= '0;
    end else begin
      unique case (st)
        S_IDLE:   st <= S_FETCH;
        S_FETCH:  if (mem_ready) st <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          unique case (1'b1)
            is_mem(opcode):     st <= S_MEMADR;
            opcode == OP_RTYPE: st <= S_REXEC;
            is_br(opcode):      st <= S_BRANCH;
            is_imm(opcode):     st <= S_IEXEC;
            opcode == OP_J:     st <= S_JUMP;
            default:            st <= S_FETCH;
          endcase
        end
        S_MEMADR: st <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) st <= S_MEMWB;
        S_MEMWR:  if (mem_ready) st <= S_FETCH;
        S_REXEC:  st <= S_RWB;
        S_IEXEC:  st <= S_IWB;
        default:  st <= S_FETCH;
      endcase
    end
  end

  // Fetch commits IR/PC only on the ready cycle; illegal flags the raw opcode.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'd0;
    zeroext     = 1'b0;
    aluop       = 3'd0;
    pcsource    = 2'd0;
    illegal     = 1'b0;
    unique case (st)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'd1;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'd3;
        illegal = !is_legal(opcode);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = 3'd2;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 3'd1;
        pcwritecond = 1'b1;
        pcsource    = 2'd1;
        branch_ne   = (op_q == OP_BNE);
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        zeroext = (op_q == OP_ANDI) || (op_q == OP_ORI);
        case (op_q)
          OP_ADDIU: aluop = 3'd5;
          OP_ANDI:  aluop = 3'd3;
          OP_ORI:   aluop = 3'd4;
          default:  aluop = 3'd0;
        endcase
      end
      S_IWB: regwrite = 1'b1;
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'd2;
      end
      default: ;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Testbench for mc_main_ctrl.
// Cycle table of inputs and expected state/outputs plus a reset sequence.
module tb_mc_main_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, branch_ne, iord;
  logic       memread, memwrite, irwrite, memtoreg;
  logic       regdst, regwrite, alusrca, zeroext, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] aluop;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_main_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .branch_ne(branch_ne),
    .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .zeroext(zeroext), .aluop(aluop), .pcsource(pcsource),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [19:0] outs;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [19:0] ov(
    input logic pw, pwc, bne, io, mr, mw, ir, m2r, rd, rw, asa,
    input logic [1:0] asb, input logic ze, input logic [2:0] aop,
    input logic [1:0] ps, input logic il);
    return {pw, pwc, bne, io, mr, mw, ir, m2r, rd, rw, asa,
            asb, ze, aop, ps, il};
  endfunction

  function automatic logic [19:0] dut_outs();
    return {pcwrite, pcwritecond, branch_ne, iord, memread, memwrite,
            irwrite, memtoreg, regdst, regwrite, alusrca,
            alusrcb, zeroext, aluop, pcsource, illegal};
  endfunction

  task automatic add(input logic r, input logic [5:0] o,
                     input logic [3:0] s, input logic [19:0] e);
    vec_t v;
    v.rdy = r; v.op = o; v.st = s; v.outs = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] es,
                     input logic [19:0] eo);
    checks++;
    if (state !== es) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", nm, state, es);
    end
    checks++;
    if (dut_outs() !== eo) begin
      errors++;
      $display("FAIL %s outs: got %05h expected %05h", nm, dut_outs(), eo);
    end
    checks++;
    if ((memread && memwrite) || (pcwrite && pcwritecond)) begin
      errors++;
      $display("FAIL %s exclusive: mr=%b mw=%b pw=%b pwc=%b expected no overlap",
               nm, memread, memwrite, pcwrite, pcwritecond);
    end
  endtask

  logic [19:0] z, f_rdy, f_stl, dec, dec_ill, madr, mrd, mwr, mwb;
  logic [19:0] rex, rwb, beq_o, bne_o, iwb, jmp;

  function automatic logic [19:0] iex(input logic [2:0] a, input logic ze);
    return ov(0,0,0,0,0,0,0,0,0,0,1, 2'd2, ze, a, 2'd0, 0);
  endfunction

  task automatic add_imm(input logic [5:0] o, input logic [2:0] a,
                         input logic ze);
    add(1, o, 4'd1, f_rdy);
    add(1, o, 4'd2, dec);
    add(1, o, 4'd10, iex(a, ze));
    add(1, o, 4'd11, iwb);
  endtask

  initial begin
    //        pw pc bn io mr mw ir m2 rd rw sa  asb ze aop ps il
    z       = '0;
    f_rdy   = ov(1,0,0,0,1,0,1,0,0,0,0, 2'd1,0,3'd0,2'd0,0);
    f_stl   = ov(0,0,0,0,1,0,0,0,0,0,0, 2'd1,0,3'd0,2'd0,0);
    dec     = ov(0,0,0,0,0,0,0,0,0,0,0, 2'd3,0,3'd0,2'd0,0);
    dec_ill = ov(0,0,0,0,0,0,0,0,0,0,0, 2'd3,0,3'd0,2'd0,1);
    madr    = ov(0,0,0,0,0,0,0,0,0,0,1, 2'd2,0,3'd0,2'd0,0);
    mrd     = ov(0,0,0,1,1,0,0,0,0,0,0, 2'd0,0,3'd0,2'd0,0);
    mwr     = ov(0,0,0,1,0,1,0,0,0,0,0, 2'd0,0,3'd0,2'd0,0);
    mwb     = ov(0,0,0,0,0,0,0,1,0,1,0, 2'd0,0,3'd0,2'd0,0);
    rex     = ov(0,0,0,0,0,0,0,0,0,0,1, 2'd0,0,3'd2,2'd0,0);
    rwb     = ov(0,0,0,0,0,0,0,0,1,1,0, 2'd0,0,3'd0,2'd0,0);
    beq_o   = ov(0,1,0,0,0,0,0,0,0,0,1, 2'd0,0,3'd1,2'd1,0);
    bne_o   = ov(0,1,1,0,0,0,0,0,0,0,1, 2'd0,0,3'd1,2'd1,0);
    iwb     = ov(0,0,0,0,0,0,0,0,0,1,0, 2'd0,0,3'd0,2'd0,0);
    jmp     = ov(1,0,0,0,0,0,0,0,0,0,0, 2'd0,0,3'd0,2'd2,0);

    add(1, 6'h00, 4'd0, z);
    add(1, 6'h00, 4'd1, f_rdy);
    add(1, 6'h00, 4'd2, dec);
    add(1, 6'h00, 4'd7, rex);
    add(1, 6'h00, 4'd8, rwb);
    add(1, 6'h23, 4'd1, f_rdy);
    add(1, 6'h23, 4'd2, dec);
    add(1, 6'h23, 4'd3, madr);
    add(0, 6'h23, 4'd4, mrd);
    add(0, 6'h23, 4'd4, mrd);
    add(1, 6'h23, 4'd4, mrd);
    add(1, 6'h23, 4'd5, mwb);
    add(1, 6'h2B, 4'd1, f_rdy);
    add(1, 6'h2B, 4'd2, dec);
    add(1, 6'h2B, 4'd3, madr);
    add(1, 6'h2B, 4'd6, mwr);
    add_imm(6'h08, 3'd0, 1'b0);
    add_imm(6'h09, 3'd5, 1'b0);
    add_imm(6'h0C, 3'd3, 1'b1);
    add_imm(6'h0D, 3'd4, 1'b1);
    add(1, 6'h04, 4'd1, f_rdy);
    add(1, 6'h04, 4'd2, dec);
    add(1, 6'h04, 4'd9, beq_o);
    add(1, 6'h05, 4'd1, f_rdy);
    add(1, 6'h05, 4'd2, dec);
    add(1, 6'h05, 4'd9, bne_o);
    add(1, 6'h02, 4'd1, f_rdy);
    add(1, 6'h02, 4'd2, dec);
    add(1, 6'h02, 4'd12, jmp);
    add(0, 6'h3F, 4'd1, f_stl);
    add(0, 6'h3F, 4'd1, f_stl);
    add(0, 6'h3F, 4'd1, f_stl);
    add(1, 6'h3F, 4'd1, f_rdy);
    add(1, 6'h3F, 4'd2, dec_ill);
    add(1, 6'h2B, 4'd1, f_rdy);
    add(1, 6'h2B, 4'd2, dec);
    add(1, 6'h2B, 4'd3, madr);
    add(0, 6'h2B, 4'd6, mwr);

    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h00;
    repeat (2) @(negedge clk);
    #1 chk("reset", 4'd0, z);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      mem_ready = tbl[i].rdy;
      opcode = tbl[i].op;
      #1 chk($sformatf("row%0d", i), tbl[i].st, tbl[i].outs);
      @(negedge clk);
    end

    // Store still waiting on memory, then reset abandons it mid-cycle.
    mem_ready = 1'b0;
    #1 chk("memwr_hold", 4'd6, mwr);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_memwr", 4'd0, z);
    @(posedge clk);
    #1 chk("reset_held", 4'd0, z);
    @(negedge clk);
    mem_ready = 1'b1;
    opcode = 6'h00;
    rst_n = 1'b1;
    #1 chk("post_rst0", 4'd0, z);
    @(negedge clk);
    #1 chk("post_rst1", 4'd1, f_rdy);
    @(negedge clk);
    #1 chk("post_rst2", 4'd2, dec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
